filter_biquad_iir: RTL and testbench

// - Generic fixed-point biquad IIR low-pass for the composite-video decode path.
// - Supersedes the hard-wired single-standard luma filters. Coefficients, widths and precision are parameters.
// - Adds a sample-valid strobe, bypass mode, output saturation at both ends and state saturation.
// - One instance per filtered signal (PAL/NTSC luma, chroma U/V), fed by the ADC/demodulator sample stream.

---
 rtl/filter_pkg.sv | 43 ++++
 rtl/filter_biquad_iir.sv | 118 +++++++++++
 tb/tb_filter_biquad_iir.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared fixed-point helpers and coefficient sets for the biquad IIR filters
// used in the composite-video decode path.
package filter_pkg;

  typedef struct packed {
    int b0;
    int b1;
    int b2;
    int a1;
    int a2;
    int a_prec;
    int b_prec;
  } biquad_coef_t;

  // Unity-DC-gain low-pass sets with two real, positive poles (no overshoot).
  localparam biquad_coef_t PAL_LUMA = '{
    b0: 24, b1: 48, b2: 24, a1: 192, a2: -32, a_prec: 8, b_prec: 8
  };
  localparam biquad_coef_t NTSC_LUMA = '{
    b0: 20, b1: 40, b2: 20, a1: 224, a2: -48, a_prec: 8, b_prec: 8
  };

  function automatic int sat_signed(input int value, input int width);
    int hi;
    int lo;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  function automatic int round_shift_clamp(input int value, input int shift, input int out_width);
    int r;
    int hi;
    hi = (1 << out_width) - 1;
    if (value < 0) return 0;
    r = value;
    if (shift > 0) r = (value + (1 << (shift - 1))) >>> shift;
    return (r > hi) ? hi : r;
  endfunction

endpackage

// File: rtl/filter_biquad_iir.sv
// Parameterised fixed-point biquad IIR with valid strobe, bypass, and saturating
// state/output. Three-stage pipeline: input capture, recursion, feed-forward.
module filter_biquad_iir
  import filter_pkg::*;
#(
  parameter int IN_WIDTH    = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int GUARD_BITS  = 2,
  parameter int STATE_WIDTH = 15,
  parameter int FIR_WIDTH   = 11,
  parameter int A_PREC      = 8,
  parameter int B_PREC      = 8,
  parameter int B0          = 256,
  parameter int B1          = 0,
  parameter int B2          = 0,
  parameter int A1          = 0,
  parameter int A2          = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in,
  input  logic                 bypass,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out
);

  if ((GUARD_BITS + IN_WIDTH >= STATE_WIDTH) || (GUARD_BITS + IN_WIDTH >= FIR_WIDTH)) begin : g_bad_widths
    $error("filter_biquad_iir: GUARD_BITS+IN_WIDTH must be below STATE_WIDTH and FIR_WIDTH");
  end

  // Index 0/1/2 = stage 1/2/3 of the valid and bypass shift pipelines.
  logic [2:0]                    r_vld;
  logic [2:0]                    r_byp;
  logic [IN_WIDTH-1:0]           r_raw1;
  logic [IN_WIDTH-1:0]           r_raw2;
  logic [IN_WIDTH-1:0]           r_raw3;
  logic signed [STATE_WIDTH-1:0] r_x;
  logic signed [STATE_WIDTH-1:0] r_rz0;
  logic signed [STATE_WIDTH-1:0] r_rz1;
  logic signed [STATE_WIDTH-1:0] r_vq;
  logic signed [FIR_WIDTH-1:0]   r_b0v;
  logic signed [FIR_WIDTH-1:0]   r_lz0;
  logic signed [FIR_WIDTH-1:0]   r_lz1;
  logic signed [FIR_WIDTH-1:0]   r_lz0_d2;

  logic signed [STATE_WIDTH-1:0] w_v;
  logic signed [STATE_WIDTH-1:0] w_rz0_d;
  logic signed [STATE_WIDTH-1:0] w_rz1_d;
  logic signed [FIR_WIDTH-1:0]   w_b0v_d;
  logic signed [FIR_WIDTH-1:0]   w_lz0_d;
  logic signed [FIR_WIDTH-1:0]   w_lz1_d;
  logic signed [FIR_WIDTH-1:0]   w_y;
  logic [OUT_WIDTH-1:0]          w_out;
  logic [OUT_WIDTH-1:0]          w_byp_out;

  // NOTE: every net here is assigned on every path, so no latch is inferred.
  always_comb begin
    w_v       = STATE_WIDTH'(sat_signed(int'(r_rz0) + int'(r_x), STATE_WIDTH));
    w_rz0_d   = STATE_WIDTH'(sat_signed(((A1 * int'(w_v)) >>> A_PREC) + int'(r_rz1), STATE_WIDTH));
    w_rz1_d   = STATE_WIDTH'(sat_signed((A2 * int'(w_v)) >>> A_PREC, STATE_WIDTH));
    w_b0v_d   = FIR_WIDTH'(sat_signed((B0 * int'(r_vq)) >>> B_PREC, FIR_WIDTH));
    w_lz0_d   = FIR_WIDTH'(sat_signed(((B1 * int'(r_vq)) >>> B_PREC) + int'(r_lz1), FIR_WIDTH));
    w_lz1_d   = FIR_WIDTH'(sat_signed((B2 * int'(r_vq)) >>> B_PREC, FIR_WIDTH));
    w_y       = FIR_WIDTH'(sat_signed(int'(r_b0v) + int'(r_lz0_d2), FIR_WIDTH));
    w_out     = OUT_WIDTH'(round_shift_clamp(int'(w_y), GUARD_BITS, OUT_WIDTH));
    w_byp_out = OUT_WIDTH'(r_raw3);
  end

  // NOTE: sequential state uses <= so each stage sees the pre-edge value of the one before.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld     <= '0;
      r_byp     <= '0;
      r_raw1    <= '0;
      r_raw2    <= '0;
      r_raw3    <= '0;
      r_x       <= '0;
      r_rz0     <= '0;
      r_rz1     <= '0;
      r_vq      <= '0;
      r_b0v     <= '0;
      r_lz0     <= '0;
      r_lz1     <= '0;
      r_lz0_d2  <= '0;
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      r_vld <= {r_vld[1:0], in_valid};
      r_byp <= {r_byp[1:0], bypass};

      if (in_valid) begin
        r_x    <= $signed(STATE_WIDTH'(in) << GUARD_BITS);
        r_raw1 <= in;
      end

      // Recursion and feed-forward only advance on valid, non-bypassed samples.
      if (r_vld[0]) r_raw2 <= r_raw1;
      if (r_vld[0] && !r_byp[0]) begin
        r_rz0 <= w_rz0_d;
        r_rz1 <= w_rz1_d;
        r_vq  <= w_v;
      end

      if (r_vld[1]) r_raw3 <= r_raw2;
      if (r_vld[1] && !r_byp[1]) begin
        r_b0v    <= w_b0v_d;
        r_lz0    <= w_lz0_d;
        r_lz1    <= w_lz1_d;
        r_lz0_d2 <= r_lz0;
      end

      out_valid <= r_vld[2];
      if (r_vld[2]) out <= r_byp[2] ? w_byp_out : w_out;
    end
  end

endmodule

// File: tb/tb_filter_biquad_iir.sv
// Scoreboard bench: four filter instances (passthrough, low-pass, gain 2, gain -1)
// share one stimulus stream; a sample-by-sample reference model predicts each output.
module tb_filter_biquad_iir;
  import filter_pkg::*;

  localparam int NI = 4;

  typedef struct packed {
    int                    due;
    logic [NI-1:0][7:0]    val;
  } exp_t;
  typedef logic [NI-1:0][7:0] rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          bypass;
  logic [7:0]    din;
  logic [NI-1:0] ov;
  logic [7:0]    ot [NI];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t sb[$];
  rec_t rec[$];

  int cb0[NI], cb1[NI], cb2[NI], ca1[NI], ca2[NI];
  int m_rz0[NI], m_rz1[NI], m_lz0[NI], m_lz1[NI];

  always #5 clk = ~clk;

  filter_biquad_iir u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .bypass(bypass),
    .out_valid(ov[0]), .out(ot[0])
  );
  filter_biquad_iir #(
    .B0(PAL_LUMA.b0), .B1(PAL_LUMA.b1), .B2(PAL_LUMA.b2), .A1(PAL_LUMA.a1), .A2(PAL_LUMA.a2)
  ) u_lp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .bypass(bypass),
    .out_valid(ov[1]), .out(ot[1])
  );
  filter_biquad_iir #(.B0(512)) u_g2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .bypass(bypass),
    .out_valid(ov[2]), .out(ot[2])
  );
  filter_biquad_iir #(.B0(-256)) u_neg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .bypass(bypass),
    .out_valid(ov[3]), .out(ot[3])
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp_w(input int val, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (val > hi) ? hi : ((val < lo) ? lo : val);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NI; i++) begin
      m_rz0[i] = 0; m_rz1[i] = 0; m_lz0[i] = 0; m_lz1[i] = 0;
    end
  endfunction

  // One whole sample through the filter, no pipeline: x -> v -> y -> out.
  function automatic int model(input int i, input int d, input bit byp);
    int x, v, b0v, lz0n, y, r;
    if (byp) return d & 255;
    x = d * 4;
    v = clamp_w(m_rz0[i] + x, 15);
    m_rz0[i] = clamp_w(((ca1[i] * v) >>> 8) + m_rz1[i], 15);
    m_rz1[i] = clamp_w((ca2[i] * v) >>> 8, 15);
    b0v  = clamp_w((cb0[i] * v) >>> 8, 11);
    lz0n = clamp_w(((cb1[i] * v) >>> 8) + m_lz1[i], 11);
    m_lz1[i] = clamp_w((cb2[i] * v) >>> 8, 11);
    y = clamp_w(b0v + m_lz0[i], 11);
    m_lz0[i] = lz0n;
    if (y < 0) return 0;
    r = (y + 2) / 4;
    return (r > 255) ? 255 : r;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    rec_t r;
    bit   exp_v;
    cyc++;
    #1;
    if (!rst) begin
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      for (int i = 0; i < NI; i++) check($sformatf("out_valid[%0d]", i), int'(ov[i]), int'(exp_v));
      if (exp_v) begin
        e = sb.pop_front();
        for (int i = 0; i < NI; i++) begin
          check($sformatf("out[%0d]", i), int'(ot[i]), int'(e.val[i]));
          r[i] = ot[i];
        end
        rec.push_back(r);
      end
    end
  end

  task automatic send(input bit v, input int d, input bit b);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    din      = d[7:0];
    bypass   = b;
    if (v) begin
      e.due = cyc + 4;
      for (int i = 0; i < NI; i++) e.val[i] = 8'(model(i, d, b));
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    repeat (6) send(1'b0, 0, 1'b0);
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic clear_all();
    sb.delete();
    rec.delete();
    model_clear();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; bypass = 1'b0; din = '0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("reset_out", int'(ot[i]), 0);
      check("reset_valid", int'(ov[i]), 0);
    end
    clear_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t1[4]   = '{0, 17, 200, 255};
    int seq[12] = '{5, 90, 250, 3, 128, 77, 200, 0, 255, 60, 31, 180};
    int pre[6]  = '{128, 128, 100, 60, 200, 150};
    int post[6] = '{90, 90, 30, 250, 10, 70};
    int ref_q[$];
    int n;
    bit ok;

    cb0 = '{256, PAL_LUMA.b0, 512, -256};
    cb1 = '{0, PAL_LUMA.b1, 0, 0};
    cb2 = '{0, PAL_LUMA.b2, 0, 0};
    ca1 = '{0, PAL_LUMA.a1, 0, 0};
    ca2 = '{0, PAL_LUMA.a2, 0, 0};
    rst = 1'b1; in_valid = 1'b0; bypass = 1'b0; din = '0;
    model_clear();

    // Passthrough, plus gain-2 / gain -1 clamping on the same samples.
    do_reset();
    foreach (t1[k]) send(1'b1, t1[k], 1'b0);
    drain();
    check("t1_count", rec.size(), 4);
    if (rec.size() == 4) begin
      foreach (t1[k]) check("t1_passthrough", int'(rec[k][0]), t1[k]);
      check("t3_gain2_clamp_hi", int'(rec[2][2]), 255);
      check("t3_neg_clamp_lo", int'(rec[2][3]), 0);
      check("t3_gain2_255", int'(rec[3][2]), 255);
    end

    // Low-pass DC settling, then step back to zero.
    do_reset();
    repeat (500) send(1'b1, 128, 1'b0);
    drain();
    n = int'(rec[rec.size()-1][1]);
    check("t2_settle_within_1", int'(n >= 127 && n <= 129), 1);
    rec.delete();
    repeat (60) send(1'b1, 0, 1'b0);
    drain();
    ok = 1'b1;
    for (int k = 1; k < rec.size(); k++) if (rec[k][1] > rec[k-1][1]) ok = 1'b0;
    check("t2_monotonic_decay", int'(ok), 1);
    check("t2_decay_to_zero", int'(rec[rec.size()-1][1]), 0);

    // Same sequence continuous vs. with valid gaps.
    do_reset();
    foreach (seq[k]) send(1'b1, seq[k], 1'b0);
    drain();
    ref_q.delete();
    foreach (rec[k]) ref_q.push_back(int'(rec[k][1]));
    do_reset();
    foreach (seq[k]) begin
      send(1'b1, seq[k], 1'b0);
      send(1'b0, 0, 1'b0);
      send(1'b0, 0, 1'b0);
    end
    drain();
    check("t4_count", rec.size(), 12);
    if (rec.size() == 12 && ref_q.size() == 12)
      foreach (seq[k]) check("t4_gapped_seq", int'(rec[k][1]), ref_q[k]);

    // Bypass mid-stream holds the filter state.
    do_reset();
    foreach (pre[k]) send(1'b1, pre[k], 1'b0);
    foreach (post[k]) send(1'b1, post[k], 1'b0);
    drain();
    ref_q.delete();
    for (int k = 6; k < rec.size(); k++) ref_q.push_back(int'(rec[k][1]));
    do_reset();
    foreach (pre[k]) send(1'b1, pre[k], 1'b0);
    for (int k = 1; k <= 4; k++) send(1'b1, 10 * k, 1'b1);
    foreach (post[k]) send(1'b1, post[k], 1'b0);
    drain();
    check("t5_count", rec.size(), 16);
    if (rec.size() == 16 && ref_q.size() == 6) begin
      for (int k = 0; k < 4; k++) check("t5_bypass_out", int'(rec[6+k][1]), 10 * (k + 1));
      foreach (post[k]) check("t5_resume", int'(rec[10+k][1]), ref_q[k]);
    end

    // Async reset mid-stream, then compare to a fresh-from-reset run.
    do_reset();
    repeat (10) send(1'b1, 128, 1'b0);
    drain();
    ref_q.delete();
    foreach (rec[k]) ref_q.push_back(int'(rec[k][1]));
    repeat (6) send(1'b1, 77, 1'b0);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("t6_async_out", int'(ot[1]), 0);
    check("t6_async_valid", int'(ov[1]), 0);
    check("t6_async_out_def", int'(ot[0]), 0);
    check("t6_async_valid_def", int'(ov[0]), 0);
    clear_all();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) send(1'b1, 128, 1'b0);
    drain();
    check("t6_count", rec.size(), 10);
    if (rec.size() == 10 && ref_q.size() == 10)
      foreach (ref_q[k]) check("t6_after_reset", int'(rec[k][1]), ref_q[k]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
